gray_ptr_sync: RTL and testbench
================================

// Module: gray_ptr_sync
// PURPOSE
//   Parametrised pointer synchroniser for async FIFO CDC: brings a Gray-coded pointer from the
//   far clock domain through an N-stage flop chain into the local domain (clk). Registers a
//   decoded binary copy, a one-cycle change strobe and the modular advance since the last
//   update, so the full/empty logic consumes a clean local-domain count.
// PARAMETERS
//   WIDTH   5  pointer width in bits (FIFO addr bits + 1 wrap bit); legal >= 2
//   STAGES  2  synchroniser flop stages; legal >= 2 (elaboration error otherwise)
// PORTS
//   clk        in   1      local (destination) clock; all flops on posedge
//   reset      in   1      asynchronous, active-high reset; all state cleared immediately
//   in_gray    in   WIDTH  Gray pointer, driven straight from a source-domain register (no logic between)
//   sync_gray  out  WIDTH  last chain stage, Gray
//   sync_bin   out  WIDTH  registered binary decode of sync_gray
//   changed    out  1      one-cycle strobe: sync_bin updated this cycle
//   delta      out  WIDTH  (new sync_bin - previous sync_bin) mod 2^WIDTH, valid with changed
//   gray_err   out  1      sticky multi-bit-jump flag (GRAY_CHECK_EN only, else constant 0)
// BEHAVIOUR
//   - Reset (async assert, deassert sampled on clk): chain stages, sync_bin, prev register,
//     changed, delta, gray_err all 0. Reset mid-operation discards in-flight values; no
//     strobe is generated by the reset itself.
//   - Chain: stage[0] <= in_gray; stage[k] <= stage[k-1]; sync_gray = stage[STAGES-1].
//     Change on in_gray visible on sync_gray STAGES edges later.
//   - Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i]; registered -> sync_bin, changed, delta
//     valid STAGES+1 edges after in_gray change (total latency STAGES+1).
//   - changed=1 for exactly one cycle iff decoded value != sync_bin held; else 0 and delta=0.
//   - delta: WIDTH-bit modular subtraction, no saturation; wrap 2^WIDTH-1 -> 0 gives delta=1.
//   - Consecutive source increments within one local cycle merge: one strobe, delta = sum.
//   - No handshake: output updates every cycle the synchronised value differs; consumer
//     must sample sync_bin/delta on the changed cycle.
//   - Pointer moves only forward; a backward jump is reported as a large modular delta.
// CONFIGURATION
//   GRAY_CHECK_EN defined: compare new sync_gray with previous registered Gray;
//     popcount(xor) > 1 sets gray_err on the next edge, held until reset. Updates and
//     delta are still produced normally. Simulation adds a $error message per occurrence.
//   GRAY_CHECK_EN undefined: checker logic absent; gray_err tied to 1'b0; port list unchanged.
// STRUCTURE
//   Shared package/include gray_ptr_pkg: functions bin2gray(WIDTH) and gray2bin(WIDTH),
//     default PTR_WIDTH=5 constant; reused by the write/read pointer counters.
//   One sub-module: sync_chain (WIDTH, STAGES, async reset) holding only the flop chain,
//     for synthesis attribute/constraint targeting; the decode/strobe/checker stays top-level.
// TESTING
//   1. Reset assert with in_gray=5'b10110 -> all outputs 0 immediately; stay 0 while reset=1.
//   2. WIDTH=5, STAGES=2: in_gray 00000->00001 -> sync_gray=00001 after 2 edges; sync_bin=1,
//      changed=1, delta=1 on edge 3; changed=0 on edge 4.
//   3. Wrap: hold in_gray=10000 (bin 31) until settled, step to 00000 -> sync_bin=0, delta=1.
//   4. Merge: two source steps (bin 3->5, Gray 00010->00111 via 00110) within one clk period
//      -> single changed strobe, delta=2.
//   5. GRAY_CHECK_EN: in_gray 00000->00011 -> gray_err=1 at edge 3, stays 1; reset clears it.
//      Without macro same stimulus -> gray_err=0, delta=2.
//   6. STAGES=3, reset asserted while change in flight -> no changed strobe; outputs 0.

Source files
------------

// File: rtl/gray_ptr_pkg.sv
// Shared Gray/binary pointer helpers, used by the pointer synchroniser and by the FIFO pointer counters.
// The helpers work at MAX_PTR_WIDTH; narrower callers zero-extend on the way in and truncate on the way out.
package gray_ptr_pkg;

  localparam int PTR_WIDTH     = 5;
  localparam int MAX_PTR_WIDTH = 32;

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits decode to zero, so the result is also correct for narrower pointers.
  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] g);
    logic [MAX_PTR_WIDTH-1:0] b;
    b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-stage flop chain for clock-domain crossing.
// It holds nothing else, so synthesis attributes and constraints can target this module alone.
module sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser: flop chain, registered binary decode, change strobe and modular advance.
// Optional macro GRAY_CHECK_EN adds a sticky flag for multi-bit jumps of the synchronised Gray value.
module gray_ptr_sync
  import gray_ptr_pkg::*;
#(
  parameter int WIDTH  = PTR_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_gray,
  output logic [WIDTH-1:0] sync_gray,
  output logic [WIDTH-1:0] sync_bin,
  output logic             changed,
  output logic [WIDTH-1:0] delta,
  output logic             gray_err
);

  if (STAGES < 2) begin : g_badStages
    $error("gray_ptr_sync: STAGES must be >= 2");
  end
  if (WIDTH < 2 || WIDTH > MAX_PTR_WIDTH) begin : g_badWidth
    $error("gray_ptr_sync: WIDTH out of range");
  end

  logic [WIDTH-1:0]         w_syncGray;
  logic [WIDTH-1:0]         w_bin;
  logic [MAX_PTR_WIDTH-1:0] w_gray32;
  logic [WIDTH-1:0]         r_bin;
  logic [WIDTH-1:0]         r_delta;
  logic                     r_changed;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .i_d   (in_gray),
    .o_q   (w_syncGray)
  );

  always_comb begin
    w_gray32             = '0;
    w_gray32[WIDTH-1:0]  = w_syncGray;
    w_bin                = WIDTH'(gray2bin(w_gray32));
  end

  // r_bin doubles as the previous value, so the advance is simply new minus held, mod 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin     <= '0;
      r_delta   <= '0;
      r_changed <= 1'b0;
    end else begin
      r_bin     <= w_bin;
      r_changed <= (w_bin != r_bin);
      r_delta   <= (w_bin != r_bin) ? (w_bin - r_bin) : '0;
    end
  end

  assign sync_gray = w_syncGray;
  assign sync_bin  = r_bin;
  assign changed   = r_changed;
  assign delta     = r_delta;

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] r_prevGray;
  logic             r_grayErr;
  logic             w_multiBit;

  assign w_multiBit = ($countones(w_syncGray ^ r_prevGray) > 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prevGray <= '0;
      r_grayErr  <= 1'b0;
    end else begin
      r_prevGray <= w_syncGray;
      if (w_multiBit) begin
        r_grayErr <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_multiBit) begin
      $error("gray_ptr_sync: multi-bit Gray jump %b -> %b", r_prevGray, w_syncGray);
    end
  end
`endif

  assign gray_err = r_grayErr;
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: scoreboard of expected (sync_bin, delta) per strobe,
// plus per-scenario inline checks on latency, wrap, merge, reset and the optional Gray checker.
module tb_gray_ptr_sync;

  localparam int W = 5;

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] delta;
  } sbEntry_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] inGray = '0;
  logic [W-1:0] syncGray, syncBin, deltaOut;
  logic         changedOut, grayErr;

  logic         rst2 = 1'b0;
  logic [W-1:0] inGray2 = '0;
  logic [W-1:0] syncGray2, syncBin2, deltaOut2;
  logic         changedOut2, grayErr2;

  int checks   = 0;
  int failures = 0;

  sbEntry_t     sb[$];
  logic [W-1:0] modelPrevBin = '0;

`ifdef GRAY_CHECK_EN
  localparam logic EXP_GRAY_ERR = 1'b1;
`else
  localparam logic EXP_GRAY_ERR = 1'b0;
`endif

  gray_ptr_sync #(.WIDTH(W), .STAGES(2)) dut (
    .clk       (clk),
    .reset     (rst),
    .in_gray   (inGray),
    .sync_gray (syncGray),
    .sync_bin  (syncBin),
    .changed   (changedOut),
    .delta     (deltaOut),
    .gray_err  (grayErr)
  );

  gray_ptr_sync #(.WIDTH(W), .STAGES(3)) dut3 (
    .clk       (clk),
    .reset     (rst2),
    .in_gray   (inGray2),
    .sync_gray (syncGray2),
    .sync_bin  (syncBin2),
    .changed   (changedOut2),
    .delta     (deltaOut2),
    .gray_err  (grayErr2)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] tbGray2Bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic [W-1:0] tbBin2Gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Drive a new source pointer; when doPush is set, the model expects one strobe for it.
  task automatic applyStimulus(input logic [W-1:0] g, input bit doPush);
    logic [W-1:0] nb;
    inGray = g;
    if (doPush) begin
      nb = tbGray2Bin(g);
      sb.push_back('{bin: nb, delta: W'(nb - modelPrevBin)});
      modelPrevBin = nb;
    end
  endtask

  task automatic waitEmpty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (changedOut === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_strobe sync_bin=%0d delta=%0d expected no strobe", syncBin, deltaOut);
      end else begin
        sbEntry_t e;
        e = sb.pop_front();
        if (syncBin !== e.bin || deltaOut !== e.delta) begin
          failures++;
          $display("[TB] FAIL sb_strobe got bin=%0d delta=%0d expected bin=%0d delta=%0d",
                   syncBin, deltaOut, e.bin, e.delta);
        end
      end
    end
  end

  task automatic test_reset();
    bit ok;
    inGray = 5'b10110;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({syncGray, syncBin, changedOut, deltaOut, grayErr} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_immediate got g=%b b=%b c=%b d=%b e=%b expected all 0",
               syncGray, syncBin, changedOut, deltaOut, grayErr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({syncGray, syncBin, changedOut, deltaOut, grayErr} !== '0) begin
        failures++;
        $display("[TB] FAIL reset_hold got g=%b b=%b c=%b d=%b expected all 0",
                 syncGray, syncBin, changedOut, deltaOut);
      end
    end
    inGray = '0;
    modelPrevBin = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 applyStimulus(5'b10110, 1'b1);
    waitEmpty(10, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL reset_first_update got pending=%0d expected 0", sb.size());
    end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({syncGray, syncBin, changedOut, deltaOut} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_midop got g=%b b=%b expected 0", syncGray, syncBin);
    end
    inGray = '0;
    modelPrevBin = '0;
    sb.delete();
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_latency();
    @(posedge clk); #1 applyStimulus(5'b00001, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        checks++;
        if (syncGray !== 5'b00000) begin
          failures++;
          $display("[TB] FAIL lat_edge1_sync_gray got %b expected 00000", syncGray);
        end
      end else if (e == 2) begin
        checks++;
        if (syncGray !== 5'b00001 || changedOut !== 1'b0) begin
          failures++;
          $display("[TB] FAIL lat_edge2 got g=%b c=%b expected g=00001 c=0", syncGray, changedOut);
        end
      end else if (e == 3) begin
        checks++;
        if (syncBin !== 5'd1 || changedOut !== 1'b1 || deltaOut !== 5'd1) begin
          failures++;
          $display("[TB] FAIL lat_edge3 got b=%0d c=%b d=%0d expected b=1 c=1 d=1",
                   syncBin, changedOut, deltaOut);
        end
      end else begin
        checks++;
        if (changedOut !== 1'b0 || deltaOut !== 5'd0) begin
          failures++;
          $display("[TB] FAIL lat_edge4 got c=%b d=%0d expected c=0 d=0", changedOut, deltaOut);
        end
      end
    end
  endtask

  // Back-to-back single increments up to 31, then the wrap to 0.
  task automatic test_back_to_back_wrap();
    bit ok;
    for (int b = 2; b <= 31; b++) begin
      @(posedge clk); #1 applyStimulus(tbBin2Gray(W'(b)), 1'b1);
    end
    waitEmpty(10, ok);
    checks++;
    if (!ok || syncBin !== 5'd31 || syncGray !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL walk_to_31 got b=%0d g=%b pending=%0d expected b=31 g=10000 pending=0",
               syncBin, syncGray, sb.size());
    end
    @(posedge clk); #1 applyStimulus(5'b00000, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (syncBin !== 5'd0 || changedOut !== 1'b1 || deltaOut !== 5'd1) begin
      failures++;
      $display("[TB] FAIL wrap got b=%0d c=%b d=%0d expected b=0 c=1 d=1", syncBin, changedOut, deltaOut);
    end
  endtask

  task automatic test_merge();
    bit ok;
    int strobes;
    logic [W-1:0] lastDelta;
    @(posedge clk); #1 applyStimulus(5'b00010, 1'b1);
    waitEmpty(10, ok);
    checks++;
    if (!ok || syncBin !== 5'd3) begin
      failures++;
      $display("[TB] FAIL merge_setup got b=%0d expected 3", syncBin);
    end
    strobes = 0;
    lastDelta = '0;
    @(posedge clk); #1 applyStimulus(5'b00110, 1'b0);
    #2 applyStimulus(5'b00111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (changedOut === 1'b1) begin
        strobes++;
        lastDelta = deltaOut;
      end
    end
    checks++;
    if (strobes != 1 || lastDelta !== 5'd2 || syncBin !== 5'd5) begin
      failures++;
      $display("[TB] FAIL merge got strobes=%0d d=%0d b=%0d expected strobes=1 d=2 b=5",
               strobes, lastDelta, syncBin);
    end
  endtask

  task automatic test_gray_check();
    @(negedge clk) rst = 1'b1;
    #1;
    inGray = '0;
    modelPrevBin = '0;
    sb.delete();
    checks++;
    if (grayErr !== 1'b0 || syncBin !== 5'd0) begin
      failures++;
      $display("[TB] FAIL gc_reset_pre got e=%b b=%0d expected e=0 b=0", grayErr, syncBin);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 applyStimulus(5'b00011, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 2) begin
        checks++;
        if (grayErr !== 1'b0) begin
          failures++;
          $display("[TB] FAIL gc_edge2 got e=%b expected 0", grayErr);
        end
      end else if (e == 3) begin
        checks++;
        if (grayErr !== EXP_GRAY_ERR || changedOut !== 1'b1 || deltaOut !== 5'd2) begin
          failures++;
          $display("[TB] FAIL gc_edge3 got e=%b c=%b d=%0d expected e=%b c=1 d=2",
                   grayErr, changedOut, deltaOut, EXP_GRAY_ERR);
        end
      end else if (e == 5) begin
        checks++;
        if (grayErr !== EXP_GRAY_ERR) begin
          failures++;
          $display("[TB] FAIL gc_sticky got e=%b expected %b", grayErr, EXP_GRAY_ERR);
        end
      end
    end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if (grayErr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gc_reset_clear got e=%b expected 0", grayErr);
    end
    inGray = '0;
    modelPrevBin = '0;
    sb.delete();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    bit sawStrobe;
    @(posedge clk); #1 inGray2 = 5'b00001;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst2 = 1'b1;
    #1;
    checks++;
    if ({syncGray2, syncBin2, changedOut2, deltaOut2, grayErr2} !== '0) begin
      failures++;
      $display("[TB] FAIL flight_reset got g=%b b=%0d c=%b expected all 0", syncGray2, syncBin2, changedOut2);
    end
    inGray2 = '0;
    @(negedge clk) rst2 = 1'b0;
    sawStrobe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (changedOut2 !== 1'b0 || syncBin2 !== 5'd0) sawStrobe = 1'b1;
    end
    checks++;
    if (sawStrobe) begin
      failures++;
      $display("[TB] FAIL flight_no_strobe got strobe/nonzero output expected none");
    end
  endtask

  initial begin
    #1 rst2 = 1'b1;
    #3 rst2 = 1'b0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back_wrap();
    test_merge();
    test_gray_check();
    test_reset_in_flight();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover got pending=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
